// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Probe counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Bit-serial successive-approximation controller: drives a trial value into an
// external comparator and rebuilds the unknown operand from its one-hot flags.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probes,
  output logic             err
);

  localparam int K_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [K_W-1:0]   K_TOP    = K_W'(WIDTH - 1);

  state_t           state;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] last_probe;
  logic             flags_ok;

  // Exactly one of the three comparator flags may be high.
  always_comb begin
    flags_ok = 1'b0;
    case ({a_gt_b, a_lt_b, a_eq_b})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // Next trial: drop bit k if we overshot, then tentatively set the next bit down.
  always_comb begin
    trial = probe;
    if (a_gt_b) trial[k] = 1'b0;
    if (k != '0) trial[k - 1'b1] = 1'b1;
  end

  always_comb begin
    last_probe = probe;
    if (a_gt_b) last_probe[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      probe  <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      probes <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= PROBE;
            probe  <= MSB_ONLY;
            k      <= K_TOP;
            probes <= '0;
            err    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
          end
        end
        PROBE: begin
          probes <= probes + 1'b1;
          if (!flags_ok) begin
            err    <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (a_eq_b) begin
            result <= probe;
            done   <= 1'b1;
            state  <= DONE;
          end else if (k == '0) begin
            result <= last_probe;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            probe <= trial;
            k     <= k - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
